lcd_frame_capture: RTL and testbench

LCD_FRAME_CAPTURE -- requirements
Module: lcd_frame_capture

---
 rtl/lcd_frame_capture.sv | 121 ++++++++++++
 tb/tb_lcd_frame_capture.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_capture.sv
// Captures 2-bit LCD pixels into packed bytes and streams them through a small
// write queue into a line-addressed framebuffer, with frame and error signalling.
module lcd_frame_capture #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LINE_BYTES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pixel_data,
  input  logic        pixel_latch,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  line_count,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic        short_line
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StSync, StActive, StFlush} state_e;

  state_e          state_q;
  logic            hsync_q, vsync_q;
  logic [7:0]      x_q, pack_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [20:0]     mem_q [FIFO_DEPTH];
  logic            frame_done_q, overflow_q, short_line_q;

  logic            hsync_rise, vsync_rise, vsync_fall;
  logic            capture, push, pop, full, accept;
  logic [7:0]      x_next, push_byte;
  logic [12:0]     push_addr;

  always_comb begin
    hsync_rise = hsync & ~hsync_q;
    vsync_rise = vsync & ~vsync_q;
    vsync_fall = ~vsync & vsync_q;
    capture    = (state_q == StActive) && pixel_latch && (x_q < 8'd160) && (line_count < 8'd144);
    push       = capture && (x_q[1:0] == 2'd3);
    pop        = (count_q != '0) && fb_ready;
    full       = (count_q == DepthCnt);
    // A full queue still takes a push when the head leaves in the same cycle.
    accept     = push && (!full || pop);
    x_next     = x_q + {7'd0, capture};
    push_byte  = {pack_q[5:0], pixel_data};
    push_addr  = 13'(line_count) * 13'(LINE_BYTES) + {7'd0, x_q[7:2]};
    count_d    = count_q + {{PtrW{1'b0}}, accept} - {{PtrW{1'b0}}, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StSync;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      x_q          <= '0;
      pack_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_line_q <= 1'b0;
    end else begin
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      frame_done_q <= 1'b0;
      count_q      <= count_d;
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
      if (capture) begin
        pack_q <= push_byte;
        x_q    <= x_next;
      end
      // The pixel arriving with the sync edge still counts toward the old group.
      if ((hsync_rise || vsync_rise) && (x_next[1:0] != 2'd0)) short_line_q <= 1'b1;
      if (hsync_rise) x_q <= '0;
      unique case (state_q)
        StSync: begin
          if (vsync_fall) begin
            state_q <= StActive;
            x_q     <= '0;
          end
        end
        StActive: begin
          if (vsync_rise) state_q <= StFlush;
        end
        StFlush: begin
          // No pushes happen here, so an empty next count means the last write is out.
          if (count_d == '0) begin
            frame_done_q <= 1'b1;
            state_q      <= StSync;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_ptr_q] <= {push_addr, push_byte};
  end

  always_comb begin
    fb_we   = pop;
    fb_addr = (count_q != '0) ? mem_q[rd_ptr_q][20:8] : '0;
    fb_data = (count_q != '0) ? mem_q[rd_ptr_q][7:0] : '0;
  end

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign short_line = short_line_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Self-checking bench for lcd_frame_capture: directed scenarios plus randomized
// frames, compared against a queue-based behavioural model of the capture rules.
module tb_lcd_frame_capture;

  localparam int unsigned Depth = 4;

  logic        clock = 1'b0;
  logic        reset, pixel_latch, hsync, vsync, fb_ready;
  logic [1:0]  pixel_data;
  logic [7:0]  line_count;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, frame_done, overflow, short_line;

  always #5 clock = ~clock;

  lcd_frame_capture #(.FIFO_DEPTH(Depth), .LINE_BYTES(40)) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_latch(pixel_latch),
    .hsync(hsync), .vsync(vsync), .line_count(line_count), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready), .frame_done(frame_done),
    .overflow(overflow), .short_line(short_line)
  );

  typedef struct {int unsigned cyc; int unsigned addr; int unsigned data;} wr_t;

  wr_t         act_w[$], exp_w[$];
  int unsigned act_fd[$], exp_fd[$];
  int          n_checks = 0, n_fail = 0;
  int unsigned cyc = 0;

  // Behavioural model state
  int          m_phase;  // 0 = waiting for frame, 1 = capturing, 2 = draining
  int unsigned m_q[$];   // {addr, data} as addr*256 + data
  int          m_grp[$];
  int          m_x;
  bit          m_prev_h, m_prev_v, m_ovf, m_short;

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_grp.delete(); m_x = 0;
    m_prev_h = 0; m_prev_v = 0; m_ovf = 0; m_short = 0;
  endtask

  task automatic model_cycle();
    bit h_rise, v_rise, v_fall;
    wr_t w;
    int unsigned b, a;
    h_rise = hsync && !m_prev_h;
    v_rise = vsync && !m_prev_v;
    v_fall = !vsync && m_prev_v;
    if (m_q.size() > 0 && fb_ready) begin
      w.cyc = cyc; w.addr = m_q[0] / 256; w.data = m_q[0] % 256;
      exp_w.push_back(w);
      m_q.delete(0);
    end
    if (m_phase == 1 && pixel_latch && m_x < 160 && line_count < 144) begin
      m_grp.push_back(int'(pixel_data));
      a = line_count * 40 + m_x / 4;
      m_x++;
      if (m_grp.size() == 4) begin
        b = m_grp[0] * 64 + m_grp[1] * 16 + m_grp[2] * 4 + m_grp[3];
        if (m_q.size() < Depth) m_q.push_back(a * 256 + b);
        else m_ovf = 1;
        m_grp.delete();
      end
    end
    if ((h_rise || v_rise) && (m_x % 4 != 0)) m_short = 1;
    if (h_rise) begin m_x = 0; m_grp.delete(); end
    if (v_rise) m_grp.delete();
    case (m_phase)
      0: if (v_fall) begin m_phase = 1; m_x = 0; m_grp.delete(); end
      1: if (v_rise) m_phase = 2;
      default: if (m_q.size() == 0) begin exp_fd.push_back(cyc + 1); m_phase = 0; end
    endcase
    m_prev_h = hsync;
    m_prev_v = vsync;
  endtask

  // Called just after a falling edge with inputs set; samples, models, advances.
  task automatic step();
    wr_t w;
    #1;
    if (reset) model_reset();
    else begin
      if (fb_we) begin
        w.cyc = cyc; w.addr = fb_addr; w.data = fb_data;
        act_w.push_back(w);
      end
      if (frame_done) act_fd.push_back(cyc);
      model_cycle();
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    pixel_latch = 0;
    repeat (n) step();
  endtask

  task automatic send_pixel(input logic [1:0] p, input logic [7:0] ly);
    pixel_data = p; line_count = ly; pixel_latch = 1;
    step();
    pixel_latch = 0;
  endtask

  task automatic hsync_pulse();
    hsync = 1; step(); hsync = 0; step();
  endtask

  task automatic begin_frame();
    vsync = 1; step(); vsync = 0; step();
  endtask

  task automatic clear_logs();
    act_w.delete(); exp_w.delete(); act_fd.delete(); exp_fd.delete();
  endtask

  task automatic test_reset();
    reset = 1; vsync = 1; hsync = 0; pixel_latch = 1; pixel_data = 2'd3;
    line_count = 0; fb_ready = 1;
    step(); step();
    reset = 0; pixel_latch = 0;
    #1;
    n_checks += 6;
    if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b expected 0", fb_we); end
    if (fb_addr !== 13'd0) begin n_fail++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
    if (fb_data !== 8'd0) begin n_fail++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    if (short_line !== 1'b0) begin n_fail++; $display("FAIL reset_short_line: got %b expected 0", short_line); end
    step();
  endtask

  task automatic test_full_line();
    clear_logs();
    begin_frame();
    for (int i = 0; i < 160; i++) send_pixel(2'd3, 8'd0);
    hsync_pulse();
    idle(4);
    n_checks++;
    if (act_w.size() != 40 || exp_w.size() != 40) begin
      n_fail++; $display("FAIL full_line_count: got %0d model %0d expected 40", act_w.size(), exp_w.size());
    end
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++) begin
      n_checks++;
      if (act_w[i].addr != i || act_w[i].data != 8'hFF || act_w[i].cyc != exp_w[i].cyc) begin
        n_fail++;
        $display("FAIL full_line_write %0d: got addr %0d data %h cyc %0d expected addr %0d data ff cyc %0d",
                 i, act_w[i].addr, act_w[i].data, act_w[i].cyc, i, exp_w[i].cyc);
      end
    end
    n_checks++;
    if (short_line !== 1'b0) begin n_fail++; $display("FAIL full_line_short: got %b expected 0", short_line); end
  endtask

  task automatic test_last_line();
    clear_logs();
    for (int i = 0; i < 4; i++) send_pixel(2'(i), 8'd143);
    idle(3);
    n_checks++;
    if (act_w.size() != 1 || exp_w.size() != 1) begin
      n_fail++; $display("FAIL last_line_count: got %0d model %0d expected 1", act_w.size(), exp_w.size());
    end else if (act_w[0].addr != 5720 || act_w[0].data != 8'h1B || act_w[0].cyc != exp_w[0].cyc) begin
      n_fail++;
      $display("FAIL last_line_write: got addr %0d data %h cyc %0d expected addr 5720 data 1b cyc %0d",
               act_w[0].addr, act_w[0].data, act_w[0].cyc, exp_w[0].cyc);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] px [20];
    int unsigned b;
    hsync_pulse();
    clear_logs();
    fb_ready = 0;
    for (int i = 0; i < 20; i++) begin
      px[i] = 2'($urandom);
      send_pixel(px[i], 8'd5);
    end
    idle(2);
    fb_ready = 1;
    idle(6);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
    n_checks++;
    if (act_w.size() != 4 || exp_w.size() != 4) begin
      n_fail++; $display("FAIL overflow_count: got %0d model %0d expected 4", act_w.size(), exp_w.size());
    end
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++) begin
      b = {px[4*i], px[4*i+1], px[4*i+2], px[4*i+3]};
      n_checks++;
      if (act_w[i].addr != 200 + i || act_w[i].data != b || act_w[i].cyc != exp_w[i].cyc) begin
        n_fail++;
        $display("FAIL overflow_write %0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 i, act_w[i].addr, act_w[i].data, act_w[i].cyc, 200 + i, b, exp_w[i].cyc);
      end
    end
  endtask

  task automatic test_hsync_same();
    hsync_pulse();
    clear_logs();
    send_pixel(2'd1, 8'd30); send_pixel(2'd2, 8'd30); send_pixel(2'd3, 8'd30);
    hsync = 1;
    send_pixel(2'd0, 8'd30);
    hsync = 0;
    for (int i = 0; i < 4; i++) send_pixel(2'd2, 8'd31);
    idle(3);
    n_checks++;
    if (act_w.size() != 2 || exp_w.size() != 2) begin
      n_fail++; $display("FAIL hsync_same_count: got %0d model %0d expected 2", act_w.size(), exp_w.size());
    end else begin
      n_checks++;
      if (act_w[0].addr != 1200 || act_w[0].data != 8'h6C || act_w[1].addr != 1240 ||
          act_w[1].data != 8'hAA) begin
        n_fail++;
        $display("FAIL hsync_same_writes: got %0d/%h %0d/%h expected 1200/6c 1240/aa",
                 act_w[0].addr, act_w[0].data, act_w[1].addr, act_w[1].data);
      end
    end
  endtask

  task automatic test_drop();
    hsync_pulse();
    clear_logs();
    for (int i = 0; i < 162; i++) send_pixel(2'($urandom), 8'd10);
    hsync_pulse();
    idle(3);
    n_checks++;
    if (act_w.size() != 40 || exp_w.size() != 40) begin
      n_fail++; $display("FAIL line162_count: got %0d model %0d expected 40", act_w.size(), exp_w.size());
    end
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++) begin
      n_checks++;
      if (act_w[i].addr != exp_w[i].addr || act_w[i].data != exp_w[i].data ||
          act_w[i].addr != 400 + i || act_w[i].cyc != exp_w[i].cyc) begin
        n_fail++;
        $display("FAIL line162_write %0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 i, act_w[i].addr, act_w[i].data, act_w[i].cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
      end
    end
    n_checks++;
    if (short_line !== 1'b0) begin n_fail++; $display("FAIL line162_short: got %b expected 0", short_line); end
    clear_logs();
    for (int i = 0; i < 8; i++) send_pixel(2'($urandom), 8'd150);
    vsync = 1;
    idle(4);
    for (int i = 0; i < 8; i++) send_pixel(2'($urandom), 8'd20);
    idle(3);
    n_checks++;
    if (act_w.size() != 0) begin n_fail++; $display("FAIL dropped_pixels: got %0d writes expected 0", act_w.size()); end
    begin_frame();
    clear_logs();
    for (int i = 0; i < 158; i++) send_pixel(2'($urandom), 8'd12);
    hsync_pulse();
    idle(3);
    n_checks += 2;
    if (act_w.size() != 39 || exp_w.size() != 39) begin
      n_fail++; $display("FAIL line158_count: got %0d model %0d expected 39", act_w.size(), exp_w.size());
    end
    if (short_line !== 1'b1) begin n_fail++; $display("FAIL line158_short: got %b expected 1", short_line); end
  endtask

  task automatic test_frame_done();
    clear_logs();
    fb_ready = 0;
    for (int i = 0; i < 12; i++) send_pixel(2'($urandom), 8'd20);
    vsync = 1;
    idle(5);
    fb_ready = 1;
    idle(8);
    n_checks++;
    if (act_w.size() != 3 || exp_w.size() != 3) begin
      n_fail++; $display("FAIL frame_done_writes: got %0d model %0d expected 3", act_w.size(), exp_w.size());
    end
    n_checks++;
    if (act_fd.size() != 1 || exp_fd.size() != 1) begin
      n_fail++; $display("FAIL frame_done_pulses: got %0d model %0d expected 1", act_fd.size(), exp_fd.size());
    end else if (act_w.size() == 3 && (act_fd[0] != act_w[2].cyc + 1 || act_fd[0] != exp_fd[0])) begin
      n_fail++;
      $display("FAIL frame_done_cycle: got %0d expected %0d", act_fd[0], act_w[2].cyc + 1);
    end
  endtask

  task automatic test_random();
    int ly;
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      begin_frame();
      for (int l = 0; l < 6; l++) begin
        ly = $urandom_range(0, 150);
        for (int k = 0; k < ((l == 2) ? 170 : $urandom_range(20, 60)); k++) begin
          fb_ready = ($urandom % 4) != 0;
          pixel_data = 2'($urandom); line_count = 8'(ly);
          pixel_latch = ($urandom % 4) != 0;
          step();
        end
        hsync = 1; pixel_latch = $urandom % 2; step();
        hsync = 0; pixel_latch = 0; step();
      end
      vsync = 1;
      for (int k = 0; k < 6; k++) begin fb_ready = $urandom % 2; step(); end
      fb_ready = 1;
      idle(8);
    end
    n_checks++;
    if (act_w.size() != exp_w.size()) begin
      n_fail++; $display("FAIL random_count: got %0d expected %0d", act_w.size(), exp_w.size());
    end
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++) begin
      n_checks++;
      if (act_w[i].addr != exp_w[i].addr || act_w[i].data != exp_w[i].data || act_w[i].cyc != exp_w[i].cyc) begin
        n_fail++;
        $display("FAIL random_write %0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 i, act_w[i].addr, act_w[i].data, act_w[i].cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
      end
    end
    n_checks++;
    if (act_fd.size() != exp_fd.size()) begin
      n_fail++; $display("FAIL random_frames: got %0d expected %0d", act_fd.size(), exp_fd.size());
    end
    for (int i = 0; i < act_fd.size() && i < exp_fd.size(); i++) begin
      n_checks++;
      if (act_fd[i] != exp_fd[i]) begin
        n_fail++; $display("FAIL random_frame_done %0d: got cyc %0d expected cyc %0d", i, act_fd[i], exp_fd[i]);
      end
    end
    n_checks += 2;
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL random_overflow: got %b expected %b", overflow, m_ovf); end
    if (short_line !== m_short) begin
      n_fail++; $display("FAIL random_short: got %b expected %b", short_line, m_short);
    end
  endtask

  task automatic test_reset_mid();
    begin_frame();
    fb_ready = 0;
    for (int i = 0; i < 16; i++) send_pixel(2'($urandom), 8'd3);
    clear_logs();
    fb_ready = 1; reset = 1;
    step();
    reset = 0;
    #1;
    n_checks++;
    if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_mid_we: got %b expected 0", fb_we); end
    idle(5);
    n_checks += 3;
    if (act_w.size() != 0) begin n_fail++; $display("FAIL reset_mid_writes: got %0d expected 0", act_w.size()); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_mid_overflow: got %b expected 0", overflow); end
    if (short_line !== 1'b0) begin n_fail++; $display("FAIL reset_mid_short: got %b expected 0", short_line); end
  endtask

  initial begin
    reset = 1; pixel_latch = 0; pixel_data = 0; hsync = 0; vsync = 1;
    line_count = 0; fb_ready = 1;
    model_reset();
    @(negedge clock);
    test_reset();
    test_full_line();
    test_last_line();
    test_overflow();
    test_hsync_same();
    test_drop();
    test_frame_done();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
